adder_share_arbiter: RTL and testbench
======================================

// Module: adder_share_arbiter
// PURPOSE
//  Shares one adder_nbit instance (WIDTH bits) among NUM_REQ requesters.
//  - Round-robin arbitration; one operation in flight at a time.
//  - Each requester offers a, b, carry_in with a valid/ready handshake.
//  - The result (sum, overflow, requester id) is returned on one shared response port.
//  - Sits between the client blocks and the single shared adder datapath.
// PARAMETERS
//  NUM_REQ  4   number of requesters (2..8)
//  WIDTH    16  operand/sum width; passed to adder_nbit #(WIDTH)
// PORTS
//  clk           in   1                  system clock, rising edge
//  rst           in   1                  synchronous, active-high reset
//  req_valid     in   NUM_REQ            requester i has an operation pending
//  req_a         in   NUM_REQ*WIDTH      operand a; slice i = [i*WIDTH +: WIDTH]
//  req_b         in   NUM_REQ*WIDTH      operand b; same slicing as req_a
//  req_cin       in   NUM_REQ            carry_in for requester i
//  req_ready     out  NUM_REQ            one-hot grant; operation accepted when valid&ready
//  rsp_valid     out  1                  response holds a valid result
//  rsp_ready     in   1                  consumer accepts the response
//  rsp_id        out  $clog2(NUM_REQ)    index of the requester that owns the result
//  rsp_sum       out  WIDTH              (a+b+cin) mod 2^WIDTH
//  rsp_overflow  out  1                  carry out of the MSB (unsigned overflow)
//  busy          out  1                  FSM is not in IDLE
// BEHAVIOUR
//  Reset (clk edge with rst=1)
//   - FSM=IDLE; rr_ptr=0; rsp_valid=0; rsp_id=0; rsp_sum=0; rsp_overflow=0.
//   - req_ready=0 whenever rst=1.
//   - Any operation in flight is dropped; no response is produced for it.
//  FSM states: IDLE -> CALC -> RESP -> IDLE.
//   IDLE
//    - Grant g = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//    - req_ready = one-hot(g), driven combinationally; all zeros if no req_valid.
//    - On grant: latch a/b/cin/id of g into operand regs; rr_ptr <= (g+1) mod NUM_REQ.
//      Next state is CALC.
//   CALC
//    - req_ready=0.
//    - The adder is fed from the operand regs.
//    - rsp_sum/rsp_overflow/rsp_id <= adder outputs and latched id; rsp_valid <= 1.
//    - Next state is RESP.
//   RESP
//    - req_ready=0; outputs held stable while rsp_valid=1.
//    - If rsp_ready=1: rsp_valid <= 0, next state IDLE. Otherwise stay in RESP.
//  Timing
//   - Grant at cycle N -> rsp_valid=1 from cycle N+2.
//   - Minimum issue interval: 3 cycles, when rsp_ready is tied high.
//  Rules
//   - rsp_ready is ignored when rsp_valid=0.
//   - req_valid may drop without a grant; no state changes.
//   - A requester whose req_valid is 1 in IDLE is granted within NUM_REQ grants.
//   - rr_ptr advances only on a grant; wraps from NUM_REQ-1 to 0.
//   - Arithmetic: full WIDTH+1-bit result; low WIDTH bits -> rsp_sum, MSB -> rsp_overflow.
//   - Operand changes on req_* after a grant do not affect the in-flight result.
//   - busy = (state != IDLE).
// TESTING
//  1. Reset, then req_valid=4'b0001 with a=16'h0001, b=16'h0002, cin=1
//     -> req_ready=4'b0001 at cycle N; rsp_valid at N+2;
//        rsp_sum=16'h0004, rsp_overflow=0, rsp_id=0.
//  2. req0: a=16'hFFFF, b=16'h0001, cin=0 -> rsp_sum=16'h0000, rsp_overflow=1.
//     req0: a=16'hFFFF, b=16'hFFFF, cin=1 -> rsp_sum=16'hFFFF, rsp_overflow=1.
//  3. req_valid=4'b1111 held, rsp_ready=1
//     -> grant order 0,1,2,3,0; rsp_id follows the same order;
//        one grant every 3 cycles.
//  4. rsp_ready=0 for 5 cycles while rsp_valid=1
//     -> rsp_* stable; req_ready=0; busy=1.
//     Then rsp_ready=1 -> IDLE next cycle; next grant the cycle after.
//  5. rst=1 asserted in CALC (req2 granted) -> next cycle rsp_valid=0, busy=0.
//     After release with req_valid=4'b0101, req0 is granted first (rr_ptr=0).
//  6. Change req_a of the granted requester during CALC
//     -> rsp_sum reflects the operands latched at grant.

Source files
------------

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing a single WIDTH-bit adder among NUM_REQ
// requesters; one operation in flight, result returned on one response port.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   req_valid       per-requester operation pending
//   req_a, req_b    packed operands, slice i = [i*WIDTH +: WIDTH]
//   req_cin         per-requester carry in
//   req_ready       one-hot grant (IDLE only, never during reset)
//   rsp_valid       response holds a valid result
//   rsp_ready       consumer accepts the response
//   rsp_id          requester index owning the result
//   rsp_sum         (a+b+cin) mod 2^WIDTH
//   rsp_overflow    carry out of the MSB
//   busy            FSM is not in IDLE

module adder_nbit #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] full;

  assign full = {1'b0, a} + {1'b0, b}
              + {{WIDTH{1'b0}}, cin};
  assign sum  = full[WIDTH-1:0];
  assign cout = full[WIDTH];

endmodule

module adder_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16,
  parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_cin,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_overflow,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   gnt_idx;
  logic             gnt_found;
  logic             do_grant;
  logic             do_load;
  logic             do_pop;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic [IDW-1:0]   op_id;

  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NUM_REQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);

  // Search rr_ptr, rr_ptr+1, ... modulo NUM_REQ for the first valid.
  always_comb begin
    logic [IDW:0]   pos;
    logic [IDW-1:0] idx;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    pos       = '0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (pos >= NREQ_W) begin
        pos = pos - NREQ_W;
      end
      idx = pos[IDW-1:0];
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    do_grant  = 1'b0;
    do_load   = 1'b0;
    do_pop    = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (gnt_found && !rst) begin
          req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1}
                      << gnt_idx;
          do_grant  = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        do_load   = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          do_pop    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operands are captured at grant so later req_* changes cannot
  // disturb the in-flight result.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      op_a   <= '0;
      op_b   <= '0;
      op_cin <= 1'b0;
      op_id  <= '0;
    end else if (do_grant) begin
      rr_ptr <= (gnt_idx == LAST_ID) ? '0
                                     : gnt_idx + 1'b1;
      op_a   <= req_a[gnt_idx*WIDTH +: WIDTH];
      op_b   <= req_b[gnt_idx*WIDTH +: WIDTH];
      op_cin <= req_cin[gnt_idx];
      op_id  <= gnt_idx;
    end
  end

  adder_nbit #(
    .WIDTH (WIDTH)
  ) u_add (
    .a    (op_a),
    .b    (op_b),
    .cin  (op_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_sum      <= '0;
      rsp_overflow <= 1'b0;
    end else if (do_load) begin
      rsp_valid    <= 1'b1;
      rsp_id       <= op_id;
      rsp_sum      <= add_sum;
      rsp_overflow <= add_cout;
    end else if (do_pop) begin
      rsp_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter: directed cases followed
// by randomized traffic checked against a behavioural model.

module tb_adder_share_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]  req_cin;
  logic [N-1:0]  req_ready;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_id;
  logic [W-1:0]  rsp_sum;
  logic          rsp_overflow;
  logic          busy;

  logic [W-1:0]  a_arr [N];
  logic [W-1:0]  b_arr [N];

  assign req_a = {a_arr[3], a_arr[2], a_arr[1], a_arr[0]};
  assign req_b = {b_arr[3], b_arr[2], b_arr[1], b_arr[0]};

  always #5 clk = ~clk;

  adder_share_arbiter #(
    .NUM_REQ (N),
    .WIDTH   (W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_cin      (req_cin),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_sum      (rsp_sum),
    .rsp_overflow (rsp_overflow),
    .busy         (busy)
  );

  int passed = 0;
  int total  = 0;

  // Model: an operation goes idle -> computing -> presenting.
  int         m_phase;
  int         m_ptr;
  logic       m_rv;
  int         m_id;
  logic [W-1:0] m_sum;
  logic       m_ov;
  logic [W-1:0] l_a;
  logic [W-1:0] l_b;
  logic       l_cin;
  int         l_id;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
  endtask

  function automatic int pick(input int ptr,
                              input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_check();
    int g;
    logic [N-1:0] er;
    g  = pick(m_ptr, req_valid);
    er = '0;
    if (!rst && m_phase == 0 && g >= 0) er[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
    chk("rsp_id", 32'(rsp_id), 32'(m_id));
    chk("rsp_sum", 32'(rsp_sum), 32'(m_sum));
    chk("rsp_ovf", 32'(rsp_overflow), 32'(m_ov));
  endtask

  task automatic model_update();
    int g;
    int s;
    if (rst) begin
      m_phase = 0; m_ptr = 0; m_rv = 1'b0;
      m_id = 0; m_sum = '0; m_ov = 1'b0;
    end else if (m_phase == 0) begin
      g = pick(m_ptr, req_valid);
      if (g >= 0) begin
        l_a = a_arr[g]; l_b = b_arr[g];
        l_cin = req_cin[g]; l_id = g;
        m_ptr = (g + 1) % N;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      s = int'(l_a) + int'(l_b) + int'(l_cin);
      m_sum = W'(s % 65536);
      m_ov  = (s >= 65536);
      m_id  = l_id;
      m_rv  = 1'b1;
      m_phase = 2;
    end else if (rsp_ready) begin
      m_rv = 1'b0;
      m_phase = 0;
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    model_check();
  endtask

  task automatic adv();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic single(input int i,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic c,
                        input logic [W-1:0] es,
                        input logic eo,
                        input string tag);
    a_arr[i] = a; b_arr[i] = b;
    req_cin = '0; req_cin[i] = c;
    req_valid = '0; req_valid[i] = 1'b1;
    rsp_ready = 1'b1;
    at_neg();
    chk({tag, "_grant"}, 32'(req_ready), 32'(1 << i));
    adv();
    req_valid = '0;
    at_neg();
    chk({tag, "_calc_rv"}, 32'(rsp_valid), 32'd0);
    adv();
    at_neg();
    chk({tag, "_rv"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_sum"}, 32'(rsp_sum), 32'(es));
    chk({tag, "_ovf"}, 32'(rsp_overflow), 32'(eo));
    chk({tag, "_id"}, 32'(rsp_id), 32'(i));
    adv();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    at_neg();
    adv();
    at_neg();
    adv();
    rst = 1'b0;
  endtask

  initial begin
    int gcyc [$];
    int gval [$];
    int ids  [$];

    rst = 1'b1;
    req_valid = '0;
    req_cin = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      a_arr[i] = '0; b_arr[i] = '0;
    end
    m_phase = 0; m_ptr = 0; m_rv = 1'b0; m_id = 0;
    m_sum = '0; m_ov = 1'b0;
    l_a = '0; l_b = '0; l_cin = 1'b0; l_id = 0;

    // Reset, with a request pending that must not be granted.
    adv();
    req_valid = 4'b0001;
    at_neg();
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rv", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    adv();
    rst = 1'b0;

    single(0, 16'h0001, 16'h0002, 1'b1,
           16'h0004, 1'b0, "t1");
    single(0, 16'hFFFF, 16'h0001, 1'b0,
           16'h0000, 1'b1, "t2a");
    single(0, 16'hFFFF, 16'hFFFF, 1'b1,
           16'hFFFF, 1'b1, "t2b");

    // Round-robin with all requesters held valid.
    do_reset();
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int c = 0; c < 13; c++) begin
      at_neg();
      if (req_ready != '0) begin
        gcyc.push_back(c);
        gval.push_back(int'(req_ready));
      end
      if (rsp_valid) ids.push_back(int'(rsp_id));
      adv();
    end
    chk("rr_count", 32'(gval.size()), 32'd5);
    for (int k = 0; k < gval.size(); k++) begin
      chk("rr_order", 32'(gval[k]), 32'(1 << (k % N)));
      chk("rr_cycle", 32'(gcyc[k]), 32'(3 * k));
    end
    chk("rr_ids_n", 32'(ids.size()), 32'd4);
    for (int k = 0; k < ids.size(); k++) begin
      chk("rr_id", 32'(ids[k]), 32'(k % N));
    end

    // Backpressure on the response port.
    req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      at_neg(); adv();
    end
    a_arr[1] = 16'h8000; b_arr[1] = 16'h8000;
    req_cin = 4'b0010;
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    at_neg();
    chk("bp_grant", 32'(req_ready), 32'b0010);
    adv();
    req_valid = 4'b1111;
    at_neg(); adv();
    for (int c = 0; c < 5; c++) begin
      at_neg();
      chk("bp_rv", 32'(rsp_valid), 32'd1);
      chk("bp_sum", 32'(rsp_sum), 32'h0001);
      chk("bp_ovf", 32'(rsp_overflow), 32'd1);
      chk("bp_id", 32'(rsp_id), 32'd1);
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
      adv();
    end
    rsp_ready = 1'b1;
    at_neg(); adv();
    at_neg();
    chk("bp_idle", 32'(busy), 32'd0);
    chk("bp_next", 32'(req_ready), 32'b0100);
    req_valid = '0;
    adv();

    // Reset while computing drops the operation.
    do_reset();
    req_valid = 4'b0100;
    at_neg();
    chk("r5_grant", 32'(req_ready), 32'b0100);
    adv();
    req_valid = '0;
    rst = 1'b1;
    at_neg();
    chk("r5_calc", 32'(busy), 32'd1);
    adv();
    at_neg();
    chk("r5_rv", 32'(rsp_valid), 32'd0);
    chk("r5_busy", 32'(busy), 32'd0);
    adv();
    rst = 1'b0;
    req_valid = 4'b0101;
    at_neg();
    chk("r5_ptr0", 32'(req_ready), 32'b0001);
    adv();
    req_valid = '0;
    for (int c = 0; c < 2; c++) begin
      at_neg(); adv();
    end

    // Operand change after grant is ignored.
    a_arr[3] = 16'h1234; b_arr[3] = 16'h1111;
    req_cin = '0;
    req_valid = 4'b1000;
    at_neg();
    chk("t6_grant", 32'(req_ready), 32'b1000);
    adv();
    req_valid = '0;
    a_arr[3] = 16'hFFFF;
    at_neg(); adv();
    at_neg();
    chk("t6_sum", 32'(rsp_sum), 32'h2345);
    chk("t6_id", 32'(rsp_id), 32'd3);
    adv();

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      req_valid = N'($urandom);
      req_cin = N'($urandom);
      rsp_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++) begin
        a_arr[i] = W'($urandom);
        b_arr[i] = W'($urandom);
      end
      if ($urandom_range(0, 7) == 0) begin
        a_arr[0] = 16'hFFFF;
        b_arr[0] = 16'hFFFF;
      end
      at_neg();
      adv();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
